// File: rtl/nn_pkg.sv
// Shared types for the layer-to-layer stream sequencer.
// Holds the FSM state encoding and the index width helper.
package nn_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } seq_state_t;

    function automatic int idx_w(input int nn);
        return (nn > 1) ? $clog2(nn) : 1;
    endfunction

endpackage

// File: rtl/layer_capture_buf.sv
// Per-neuron result buffer with capture mask and overrun detection.
// Captures while collecting and on the final transfer of a burst.
module layer_capture_buf
    import nn_pkg::*;
#(
    parameter int NN = 10,
    parameter int DW = 16,
    parameter int IW = idx_w(NN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             collect,
    input  logic             fin,
    input  logic [NN-1:0]    i_valid,
    input  logic [NN*DW-1:0] i_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [DW-1:0]    rd_data,
    output logic             all_captured,
    output logic             overrun
);

    logic [NN-1:0] cap;
    logic [DW-1:0] mem [NN];
    logic          wr_en;
    logic          dup_hit;
    logic          send_hit;

    assign wr_en        = collect | fin;
    assign all_captured = &(cap | i_valid);
    assign rd_data      = mem[rd_idx];
    assign dup_hit      = collect & (|(cap & i_valid));
    assign send_hit     = ~collect & ~fin & (|i_valid);

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NN; k++) begin
            if (wr_en && i_valid[k]) begin
                mem[k] <= i_data[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cap     <= '0;
            overrun <= 1'b0;
        end else begin
            if (fin) begin
                cap <= i_valid;
            end else if (collect) begin
                cap <= cap | i_valid;
            end
            if (dup_hit || send_hit) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_stream_sequencer.sv
// Collects one layer's parallel results and replays them as a
// serial valid/ready stream for the next layer.
module layer_stream_sequencer
    import nn_pkg::*;
#(
    parameter int NN        = 10,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    input  logic                    o_ready,
    output logic                    o_valid,
    output logic [dataWidth-1:0]    o_data,
    output logic                    o_last,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IW = idx_w(NN);
    localparam logic [IW-1:0] LAST = IW'(NN - 1);

    seq_state_t           state;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        nxt_idx;
    logic [IW-1:0]        rd_idx;
    logic [dataWidth-1:0] rd_data;
    logic                 all_captured;
    logic                 collect;
    logic                 xfer;
    logic                 fin;

    assign collect = (state == COLLECT);
    assign xfer    = o_valid & o_ready;
    assign fin     = (state == SEND) & xfer & (idx == LAST);
    assign nxt_idx = (idx == LAST) ? idx : idx + IW'(1);
    assign rd_idx  = collect ? '0 : nxt_idx;

    layer_capture_buf #(
        .NN (NN),
        .DW (dataWidth),
        .IW (IW)
    ) u_cap (
        .clk          (clk),
        .rst          (rst),
        .collect      (collect),
        .fin          (fin),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data),
        .all_captured (all_captured),
        .overrun      (overrun)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= COLLECT;
            idx     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                COLLECT: begin
                    if (all_captured) begin
                        state   <= SEND;
                        idx     <= '0;
                        o_valid <= 1'b1;
                        o_last  <= 1'b0;
                        busy    <= 1'b1;
                        // Word 0 may arrive in this very cycle.
                        o_data  <= i_valid[0] ? i_data[dataWidth-1:0]
                                              : rd_data;
                    end
                end
                SEND: begin
                    if (fin) begin
                        state   <= COLLECT;
                        idx     <= '0;
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        busy    <= 1'b0;
                    end else if (xfer) begin
                        idx    <= nxt_idx;
                        o_data <= rd_data;
                        o_last <= (nxt_idx == LAST);
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Randomized scoreboard bench for layer_stream_sequencer.
// A burst-level reference model predicts the replayed word stream.
module tb_layer_stream_sequencer;

    localparam int NN = 10;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NN-1:0]    i_valid = '0;
    logic [NN*DW-1:0] i_data = '0;
    logic             o_ready = 1'b0;
    logic             o_valid;
    logic [DW-1:0]    o_data;
    logic             o_last;
    logic             busy;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t          expq[$];
    bit            mcap[NN];
    logic [DW-1:0] mbuf[NN];
    bit            msend = 1'b0;
    int            msent = 0;
    bit            movr  = 1'b0;

    layer_stream_sequencer #(
        .NN        (NN),
        .dataWidth (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // A transfer happens at the next rising edge when valid & ready.
    always @(negedge clk) begin
        if (rst === 1'b1 && o_valid === 1'b1 && o_ready === 1'b1) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h expected none",
                         o_data);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("o_data", 32'(o_data), 32'(e.d));
                chk("o_last", 32'(o_last), 32'(e.last));
            end
        end
    end

    task automatic model_step(input logic [NN-1:0] v,
                              input logic [NN*DW-1:0] d,
                              input bit rdy, input bit rs);
        bit all;
        if (!rs) begin
            msend = 1'b0;
            msent = 0;
            movr  = 1'b0;
            foreach (mcap[k]) mcap[k] = 1'b0;
            expq.delete();
            return;
        end
        if (!msend) begin
            for (int k = 0; k < NN; k++) begin
                if (v[k]) begin
                    if (mcap[k]) movr = 1'b1;
                    mcap[k] = 1'b1;
                    mbuf[k] = d[k*DW +: DW];
                end
            end
            all = 1'b1;
            foreach (mcap[k]) all &= mcap[k];
            if (all) begin
                for (int k = 0; k < NN; k++) begin
                    expq.push_back('{d: mbuf[k], last: (k == NN - 1)});
                    mcap[k] = 1'b0;
                end
                msend = 1'b1;
                msent = 0;
            end
        end else if (rdy && msent == NN - 1) begin
            msend = 1'b0;
            msent = 0;
            for (int k = 0; k < NN; k++) begin
                mcap[k] = v[k];
                if (v[k]) mbuf[k] = d[k*DW +: DW];
            end
        end else begin
            if (rdy) msent++;
            if (v != '0) movr = 1'b1;
        end
    endtask

    task automatic cycle(input logic [NN-1:0] v,
                         input logic [NN*DW-1:0] d,
                         input bit rdy, input bit rs);
        i_valid = v;
        i_data  = d;
        o_ready = rdy;
        rst     = rs;
        model_step(v, d, rdy, rs);
        @(posedge clk);
        #1;
        chk("o_valid", 32'(o_valid), 32'(msend));
        chk("busy", 32'(busy), 32'(msend));
        chk("overrun", 32'(overrun), 32'(movr));
        if (!rs) begin
            chk("rst_o_data", 32'(o_data), 32'h0);
            chk("rst_o_last", 32'(o_last), 32'h0);
        end
    endtask

    function automatic logic [NN*DW-1:0] rand_data();
        logic [NN*DW-1:0] d;
        for (int k = 0; k < NN; k++) d[k*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    task automatic drain();
        for (int i = 0; i < 4 * NN && (msend || expq.size() != 0); i++) begin
            cycle('0, rand_data(), 1'b1, 1'b1);
        end
        cycle('0, rand_data(), 1'b1, 1'b1);
    endtask

    initial begin
        logic [NN*DW-1:0] d;
        logic [NN-1:0]    full;
        logic [NN-1:0]    v;
        full = '1;

        cycle('0, '0, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // Words 1..NN in a single cycle.
        for (int k = 0; k < NN; k++) d[k*DW +: DW] = DW'(k + 1);
        cycle(full, d, 1'b1, 1'b1);
        drain();

        // Staggered capture: low half then high half three cycles later.
        d = rand_data();
        cycle(NN'(10'h01f), d, 1'b1, 1'b1);
        cycle('0, rand_data(), 1'b1, 1'b1);
        cycle('0, rand_data(), 1'b1, 1'b1);
        cycle(NN'(10'h3e0), d, 1'b1, 1'b1);
        drain();

        // Back-pressure pattern 1,0,0,1.
        cycle(full, rand_data(), 1'b1, 1'b1);
        for (int i = 0; i < 8 * NN && msend; i++) begin
            cycle('0, rand_data(), (i % 4 == 0) || (i % 4 == 3), 1'b1);
        end
        drain();

        // Next burst arrives on the final transfer.
        cycle(full, rand_data(), 1'b1, 1'b1);
        for (int i = 0; i < 2 * NN && msend && msent != NN - 1; i++) begin
            cycle('0, rand_data(), 1'b1, 1'b1);
        end
        cycle(full, rand_data(), 1'b1, 1'b1);
        drain();

        // Stray valid during replay.
        cycle(full, rand_data(), 1'b1, 1'b1);
        cycle('0, rand_data(), 1'b1, 1'b1);
        cycle('0, rand_data(), 1'b1, 1'b1);
        cycle(NN'(10'h008), rand_data(), 1'b1, 1'b1);
        drain();

        // Reset in the middle of a burst.
        cycle(full, rand_data(), 1'b1, 1'b1);
        for (int i = 0; i < 2 * NN && msend && msent != 4; i++) begin
            cycle('0, rand_data(), 1'b1, 1'b1);
        end
        cycle('0, rand_data(), 1'b1, 1'b0);
        cycle(full, rand_data(), 1'b1, 1'b1);
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            v = '0;
            if (!msend ? ($urandom_range(0, 2) == 0)
                       : ($urandom_range(0, 19) == 0)) begin
                v = NN'($urandom);
            end
            cycle(v, rand_data(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 199) != 0);
        end
        drain();

        chk("queue_empty", 32'(expq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
